// File: rtl/softmax_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : softmax_normalizer
// Purpose  : Buffers one frame of Q0.16 exponents, divides 2^27 by the Q5.11
//            frame sum with a restoring divider, then emits each element
//            scaled by the reciprocal as a framed Q0.16 probability stream.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_normalizer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        iClk,
  input  logic        iRsn,
  input  logic        iExpValid,
  output logic        oExpReady,
  input  logic        iExpLast,
  input  logic [15:0] iExpData,
  input  logic        iSumValid,
  output logic        oSumReady,
  input  logic [15:0] iSumData,
  output logic        oValid,
  input  logic        iReady,
  output logic        oLast,
  output logic [15:0] oData,
  output logic        oErr
);

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_WAIT_SUM = 2'd1,
    ST_DIV      = 2'd2,
    ST_EMIT     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] c_one   = 1;
  localparam logic [4:0]      c_div_n = 5'd28;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    wr_q, wr_d;
  logic [ADDR_W:0]    rd_q, rd_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [27:0]        recip_q, recip_d;
  logic [15:0]        sum_q, sum_d;
  logic [16:0]        rem_q, rem_d;
  logic [27:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               ovalid_q, ovalid_d;
  logic               olast_q, olast_d;
  logic [15:0]        odata_q, odata_d;
  logic               err_q, err_d;

  logic [15:0]        mem_q [DEPTH];
  logic               mem_we;

  logic               exp_hs, sum_hs, out_hs, load;
  logic [15:0]        mem_rd;
  logic [43:0]        prod;
  logic [44:0]        rnd;
  logic [44:0]        q_full;
  logic [15:0]        q_sat;
  logic [17:0]        rem_shift;
  logic [17:0]        rem_diff;
  logic               rem_ge;

  assign oExpReady = (state_q == ST_FILL);
  assign oSumReady = (state_q == ST_WAIT_SUM);
  assign oValid    = ovalid_q;
  assign oLast     = olast_q;
  assign oData     = odata_q;
  assign oErr      = err_q;

  assign exp_hs = iExpValid && oExpReady;
  assign sum_hs = iSumValid && oSumReady;
  assign out_hs = ovalid_q && iReady;
  assign load   = (state_q == ST_EMIT) && (!ovalid_q || iReady) && (rd_q < len_q);

  // Scale the current element by the reciprocal, round half-up, saturate.
  assign mem_rd = mem_q[rd_q[ADDR_W-1:0]];
  assign prod   = {28'd0, mem_rd} * {16'd0, recip_q};
  assign rnd    = {1'b0, prod} + 45'd32768;
  assign q_full = rnd >> 16;
  assign q_sat  = (|q_full[44:16]) ? 16'hFFFF : q_full[15:0];

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_q, quo_q[27]};
  assign rem_diff  = rem_shift - {2'b00, sum_q};
  assign rem_ge    = !rem_diff[17];

  // Frame buffer write port; contents are not reset, only indices are.
  always_ff @(posedge iClk) begin
    if (mem_we) mem_q[wr_q[ADDR_W-1:0]] <= iExpData;
  end

  // Next-state and datapath control for fill, divide and emit phases.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    len_d    = len_q;
    recip_d  = recip_q;
    sum_d    = sum_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    odata_d  = odata_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (exp_hs) begin
          if (wr_q < c_depth) begin
            mem_we = 1'b1;
            wr_d   = wr_q + c_one;
          end else begin
            err_d = 1'b1;
          end
          if (iExpLast) begin
            len_d   = (wr_q < c_depth) ? (wr_q + c_one) : c_depth;
            state_d = ST_WAIT_SUM;
          end
        end
      end
      ST_WAIT_SUM: begin
        if (sum_hs) begin
          sum_d   = iSumData;
          rem_d   = 17'd0;
          quo_d   = 28'h8000000;
          cnt_d   = 5'd0;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        // 28 iteration cycles, then one cycle to publish the quotient.
        if (cnt_q == c_div_n) begin
          recip_d = (sum_q == 16'd0) ? 28'hFFFFFFF : quo_q;
          rd_d    = '0;
          state_d = ST_EMIT;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (sum_q != 16'd0) begin
            rem_d = rem_ge ? rem_diff[16:0] : rem_shift[16:0];
            quo_d = {quo_q[26:0], rem_ge};
          end
        end
      end
      ST_EMIT: begin
        if (out_hs) ovalid_d = 1'b0;
        if (load) begin
          ovalid_d = 1'b1;
          odata_d  = q_sat;
          olast_d  = (rd_q == (len_q - c_one));
          rd_d     = rd_q + c_one;
        end
        if (out_hs && olast_q) begin
          olast_d = 1'b0;
          wr_d    = '0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q  <= ST_FILL;
      wr_q     <= '0;
      rd_q     <= '0;
      len_q    <= '0;
      recip_q  <= '0;
      sum_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      odata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      len_q    <= len_d;
      recip_q  <= recip_d;
      sum_q    <= sum_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      odata_q  <= odata_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire
